// File: rtl/store_unit.sv
// MEM-stage store path: alignment check, lane steering, SRAM write handshake.
// One outstanding store; completion or AdES reported as one-cycle pulses.
module store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_type,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              data_sram_req,
  output logic              data_sram_wr,
  output logic [1:0]        data_sram_size,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [3:0]        data_sram_wstrb,
  output logic [DATA_W-1:0] data_sram_wdata,
  input  logic              data_sram_addr_ok,
  input  logic              data_sram_data_ok,
  output logic              st_done,
  output logic              st_ex,
  output logic [ADDR_W-1:0] st_badvaddr
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t state, state_n;

  logic              mis;
  logic              load;
  logic              done_n;
  logic              ex_n;
  logic              cancel;
  logic              cancel_n;
  logic [1:0]        size_n;
  logic [3:0]        strb_n;
  logic [DATA_W-1:0] wdata_n;

  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        strb_q;
  logic [DATA_W-1:0] wdata_q;

  always_comb begin
    size_n  = 2'd2;
    strb_n  = 4'b0000;
    wdata_n = in_data;
    mis     = 1'b0;
    unique case (1'b1)
      in_type[0]: begin
        size_n  = 2'd0;
        strb_n  = 4'b0001 << in_addr[1:0];
        wdata_n = {4{in_data[7:0]}};
      end
      in_type[1]: begin
        size_n  = 2'd1;
        strb_n  = in_addr[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{in_data[15:0]}};
        mis     = in_addr[0];
      end
      in_type[2]: begin
        strb_n = 4'b1111;
        mis    = |in_addr[1:0];
      end
      default: ;
    endcase
  end

  // cancel marks a write already in memory whose completion must stay silent
  always_comb begin
    state_n  = state;
    load     = 1'b0;
    done_n   = 1'b0;
    ex_n     = 1'b0;
    cancel_n = cancel;
    unique case (state)
      IDLE: begin
        if (in_valid && !flush) begin
          if (mis) begin
            ex_n = 1'b1;
          end else begin
            load    = 1'b1;
            state_n = REQ;
          end
        end
      end
      REQ: begin
        if (data_sram_addr_ok) begin
          if (data_sram_data_ok) begin
            state_n = IDLE;
            done_n  = !flush;
          end else begin
            state_n  = WAIT;
            cancel_n = flush;
          end
        end else if (flush) begin
          state_n = IDLE;
        end
      end
      WAIT: begin
        if (data_sram_data_ok) begin
          state_n  = IDLE;
          done_n   = !(cancel || flush);
          cancel_n = 1'b0;
        end else if (flush) begin
          cancel_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cancel      <= 1'b0;
      st_done     <= 1'b0;
      st_ex       <= 1'b0;
      st_badvaddr <= '0;
      size_q      <= '0;
      addr_q      <= '0;
      strb_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state   <= state_n;
      cancel  <= cancel_n;
      st_done <= done_n;
      st_ex   <= ex_n;
      if (ex_n) st_badvaddr <= in_addr;
      if (load) begin
        size_q  <= size_n;
        addr_q  <= in_addr;
        strb_q  <= strb_n;
        wdata_q <= wdata_n;
      end
    end
  end

  assign in_ready        = (state == IDLE);
  assign data_sram_req   = (state == REQ);
  assign data_sram_wr    = data_sram_req;
  assign data_sram_size  = size_q;
  assign data_sram_addr  = addr_q;
  assign data_sram_wstrb = strb_q;
  assign data_sram_wdata = wdata_q;

endmodule
